// File: rtl/o_delay_tap_ctrl.sv
// Tap controller for an O_DELAY primitive: steps DLY_TAP_VALUE one tap at a time toward a requested target.
// Optional stall detection is built when O_DELAY_TAP_CTRL_STALL_DET_EN is defined; otherwise err_o is tied low.
module o_delay_tap_ctrl #(
  parameter int TAP_W      = 6,
  parameter int MAX_TAP    = 63,
  parameter int SETTLE_CYC = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [TAP_W-1:0] target_tap_i,
  input  logic             load_i,
  input  logic [TAP_W-1:0] dly_tap_val_i,
  output logic             dly_ld_o,
  output logic             dly_adj_o,
  output logic             dly_incdec_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STEP    = 3'd2,
    SETTLE  = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [TAP_W-1:0] MAX_T       = TAP_W'(MAX_TAP);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t           state;
  logic [TAP_W-1:0] target;
  logic [TAP_W-1:0] target_clamped;
  logic [TAP_W:0]   target_wide;
  logic [3:0]       settle_cnt;
  logic             stall_hit;

  // One extra bit so the clamp compare stays meaningful when MAX_TAP is the full TAP_W range.
  assign target_wide    = {1'b0, target_tap_i};
  assign target_clamped = (target_wide > (TAP_W+1)'(MAX_TAP)) ? MAX_T : target_tap_i;

`ifdef O_DELAY_TAP_CTRL_STALL_DET_EN
  logic [TAP_W-1:0] prev_tap;
  logic [2:0]       stall_cnt;
  logic             stepped;
  logic             err;

  // Fourth consecutive compare after a step that sees no tap movement.
  assign stall_hit = stepped && (dly_tap_val_i == prev_tap) && (stall_cnt == 3'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_tap  <= '0;
      stall_cnt <= '0;
      stepped   <= 1'b0;
      err       <= 1'b0;
    end else if (state == IDLE && req_valid_i) begin
      stall_cnt <= '0;
      stepped   <= 1'b0;
      err       <= 1'b0;
    end else if (state == STEP) begin
      stepped <= 1'b1;
    end else if (state == COMPARE) begin
      prev_tap <= dly_tap_val_i;
      if (stepped && dly_tap_val_i == prev_tap) stall_cnt <= stall_cnt + 3'd1;
      else                                      stall_cnt <= '0;
      if (stall_hit && dly_tap_val_i != target) err <= 1'b1;
    end
  end

  assign err_o = err;
`else
  assign stall_hit = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      target       <= '0;
      settle_cnt   <= '0;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      dly_ld_o     <= 1'b0;
      dly_adj_o    <= 1'b0;
      dly_incdec_o <= 1'b0;
    end else begin
      dly_ld_o  <= 1'b0;
      dly_adj_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            target      <= target_clamped;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (load_i) begin
              state    <= LOAD;
              dly_ld_o <= 1'b1;
            end else begin
              state <= COMPARE;
            end
          end
        end
        LOAD, STEP: begin
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= COMPARE;
          else                           settle_cnt <= settle_cnt + 4'd1;
        end
        COMPARE: begin
          if (dly_tap_val_i == target || stall_hit) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else if (dly_tap_val_i < target) begin
            // Top of the line reached: finish where we are rather than overrun it.
            if (dly_tap_val_i >= MAX_T) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state        <= STEP;
              dly_adj_o    <= 1'b1;
              dly_incdec_o <= 1'b1;
            end
          end else begin
            state        <= STEP;
            dly_adj_o    <= 1'b1;
            dly_incdec_o <= 1'b0;
          end
        end
        DONE: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_o_delay_tap_ctrl.sv
// Scoreboard bench for o_delay_tap_ctrl with a behavioural O_DELAY tap model.
// Expected ld/adj pulses and done events are queued at request time from the documented timing.
module tb_o_delay_tap_ctrl;
  localparam int TAP_W    = 7;
  localparam int MAX_TAP  = 63;
  localparam int SETTLE   = 3;
  localparam int STEP_CYC = SETTLE + 2;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_valid = 1'b0;
  logic             load = 1'b0;
  logic [TAP_W-1:0] target_tap = '0;
  logic [TAP_W-1:0] tap_m = '0;
  logic [TAP_W-1:0] load_val = '0;
  logic             stuck = 1'b0;
  logic             req_ready, dly_ld, dly_adj, dly_incdec, busy, done, err;

  typedef struct {int cyc; int dir;} adj_t;
  typedef struct {int cyc; int tap; int err;} done_t;

  int    ldq[$];
  adj_t  adjq[$];
  done_t doneq[$];
  int    ld_e;
  adj_t  adj_e;
  done_t done_e;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    exp_tap = 0;
  logic  prev_pulse = 1'b0;

  o_delay_tap_ctrl #(.TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .SETTLE_CYC(SETTLE)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .target_tap_i(target_tap), .load_i(load), .dly_tap_val_i(tap_m),
    .dly_ld_o(dly_ld), .dly_adj_o(dly_adj), .dly_incdec_o(dly_incdec),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // O_DELAY model: load or single-tap step on the clock edge; 'stuck' ignores DLY_ADJ.
  always @(posedge clk) begin
    if (dly_ld) tap_m <= load_val;
    else if (dly_adj && !stuck) tap_m <= dly_incdec ? tap_m + 7'd1 : tap_m - 7'd1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (dly_ld || dly_adj) begin
        check("ld_adj_apart", int'(prev_pulse), 0);
        check("ld_adj_excl", int'(dly_ld & dly_adj), 0);
      end
      if (dly_ld) begin
        if (ldq.size() == 0) check("ld_unexpected", int'(dly_ld), 0);
        else begin
          ld_e = ldq.pop_front();
          check("ld_cyc", cyc, ld_e);
        end
      end
      if (dly_adj) begin
        if (adjq.size() == 0) check("adj_unexpected", int'(dly_adj), 0);
        else begin
          adj_e = adjq.pop_front();
          check("adj_cyc", cyc, adj_e.cyc);
          check("adj_dir", int'(dly_incdec), adj_e.dir);
        end
      end
      if (done) begin
        if (doneq.size() == 0) check("done_unexpected", int'(done), 0);
        else begin
          done_e = doneq.pop_front();
          check("done_cyc", cyc, done_e.cyc);
          check("done_tap", int'(tap_m), done_e.tap);
          check("done_err", int'(err), done_e.err);
        end
      end
      prev_pulse <= dly_ld | dly_adj;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  task automatic do_req(input int tgt, input bit ld, input int lval);
    int t, cur, tc, cmp, dir;
    @(negedge clk);
    load_val   = TAP_W'(lval);
    target_tap = TAP_W'(tgt);
    load       = ld;
    req_valid  = 1'b1;
    t   = cyc;
    cur = ld ? lval : exp_tap;
    tc  = (tgt > MAX_TAP) ? MAX_TAP : tgt;
    if (ld) ldq.push_back(t + 1);
    cmp = t + (ld ? SETTLE + 2 : 1);
    if (stuck) begin
      dir = (cur < tc) ? 1 : 0;
`ifdef O_DELAY_TAP_CTRL_STALL_DET_EN
      for (int k = 0; k < 4; k++) adjq.push_back('{cmp + 1 + k*STEP_CYC, dir});
      doneq.push_back('{cmp + 1 + 4*STEP_CYC, cur, 1});
`else
      for (int k = 0; k < 6; k++) adjq.push_back('{cmp + 1 + k*STEP_CYC, dir});
`endif
    end else begin
      while (cur != tc) begin
        dir = (cur < tc) ? 1 : 0;
        adjq.push_back('{cmp + 1, dir});
        cur = dir ? cur + 1 : cur - 1;
        cmp += STEP_CYC;
      end
      doneq.push_back('{cmp + 1, cur, 0});
    end
    exp_tap = cur;
    $display("req cyc=%0d target=%0d load=%0d load_val=%0d stuck=%0d exp_steps=%0d",
             t, tgt, ld, lval, stuck, adjq.size());
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("ready_low", int'(req_ready), 0);
    check("busy_high", int'(busy), 1);
    check("err_cleared", int'(err), 0);
  endtask

  task automatic wait_drain(input int budget, input bit idle_expected);
    int n;
    n = 0;
    while (n < budget && (ldq.size() + adjq.size() + doneq.size()) != 0) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", ldq.size() + adjq.size() + doneq.size(), 0);
    ldq.delete(); adjq.delete(); doneq.delete();
    if (idle_expected) begin
      @(negedge clk);
      #1;
      check("ready_back", int'(req_ready), 1);
      check("busy_back", int'(busy), 0);
    end
  endtask

  task automatic reset_pulse(input string tag);
    #2;
    rst_ni = 1'b0;
    #1;
    check({tag, "_ready"}, int'(req_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_ld"}, int'(dly_ld), 0);
    check({tag, "_adj"}, int'(dly_adj), 0);
    check({tag, "_incdec"}, int'(dly_incdec), 0);
    ldq.delete(); adjq.delete(); doneq.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check({tag, "_idle_ready"}, int'(req_ready), 1);
    check({tag, "_idle_busy"}, int'(busy), 0);
    $display("reset %s released, tap=%0d", tag, tap_m);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_ld", int'(dly_ld), 0);
    check("rst_adj", int'(dly_adj), 0);
    check("rst_incdec", int'(dly_incdec), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_ready", int'(req_ready), 1);

    do_req(10, 1'b1, 10);           // load straight onto target
    wait_drain(100, 1'b1);
    do_req(13, 1'b0, 0);            // 10 -> 13 by increments
    wait_drain(100, 1'b1);
    do_req(18, 1'b1, 20);           // load 20, two decrements
    req_valid  = 1'b1;              // ignored while busy
    target_tap = 7'd5;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    wait_drain(100, 1'b1);
    do_req(18, 1'b0, 0);            // already at target
    wait_drain(100, 1'b1);
    do_req(70, 1'b1, 62);           // clamp to MAX_TAP
    wait_drain(100, 1'b1);
    repeat (10) @(negedge clk);

    stuck = 1'b1;
    do_req(5, 1'b1, 0);
`ifdef O_DELAY_TAP_CTRL_STALL_DET_EN
    wait_drain(200, 1'b1);
    check("err_sticky", int'(err), 1);
    stuck = 1'b0;
    do_req(3, 1'b0, 0);
    wait_drain(100, 1'b1);
`else
    wait_drain(200, 1'b0);
    @(negedge clk);
    stuck = 1'b0;
    reset_pulse("stall_rst");
    exp_tap = int'(tap_m);
`endif

    do_req(4, 1'b1, 0);             // reset while settling after the first step
    while (adjq.size() > 3 && cyc < 5000) begin
      @(negedge clk);
      #1;
    end
    check("first_step_seen", adjq.size(), 3);
    @(negedge clk);
    reset_pulse("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
